// File: rtl/mix_field_unit.sv
// Purpose : MIX partial-field unit; extracts field (L:R) of a memory word for LDx/LDxN
//           and merges a register value into field (L:R) of a memory word for STx.
// Latency : 1 cycle (in_valid at edge k -> results and out_valid registered at edge k).
// Backpressure: none; accepts one capture per cycle, results hold while in_valid is low.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   in_valid          capture request for f / mem_word / reg_word
//   f[5:0]            field spec F = 8L+R (L = f[5:3], R = f[2:0])
//   mem_word[30:0]    load source and store merge target (bit 30 = sign)
//   reg_word[30:0]    register value to store
//   out_valid         one-cycle pulse after each capture
//   load_out[30:0]    extracted field, right-justified
//   store_out[30:0]   merged word for memory write-back
//   err               invalid-field flag, present only when MIX_FIELD_ERR_EN is defined
module mix_field_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [5:0]  f,
    input  logic [30:0] mem_word,
    input  logic [30:0] reg_word,
    output logic        out_valid,
    output logic [30:0] load_out,
    output logic [30:0] store_out
`ifdef MIX_FIELD_ERR_EN
    ,
    output logic        err
`endif
);

    logic [2:0]  fld_l;
    logic [2:0]  fld_r;
    logic [2:0]  fld_lo;     // first byte of the field; the sign position counts as byte 0
    logic [2:0]  fld_n;      // number of magnitude bytes in the field
    logic [2:0]  r_gap;      // bytes between the field's last byte and byte 5
    logic        fld_ok;
    logic [4:0]  sh;
    logic [4:0]  nbits;
    logic [29:0] nmask;
    logic [29:0] fmask;
    logic [30:0] load_new;
    logic [30:0] store_new;

    logic        out_valid_d, out_valid_q;
    logic [30:0] load_out_d,  load_out_q;
    logic [30:0] store_out_d, store_out_q;

    always_comb begin
        fld_l  = f[5:3];
        fld_r  = f[2:0];
        fld_ok = (fld_l <= fld_r) && (fld_r <= 3'd5);
        fld_lo = (fld_l == 3'd0) ? 3'd1 : fld_l;
        // (0:0) yields zero magnitude bytes: 0 - 1 + 1 wraps back to 0.
        fld_n  = fld_r - fld_lo + 3'd1;
        r_gap  = 3'd5 - fld_r;
        sh     = 5'(r_gap) * 5'd6;
        nbits  = 5'(fld_n) * 5'd6;
        // A full 5-byte field shifts the 1 out of the 30-bit word, leaving all ones.
        nmask  = (30'd1 << nbits) - 30'd1;
        fmask  = nmask << sh;

        load_new  = '0;
        store_new = mem_word;
        if (fld_ok) begin
            load_new[30]    = (fld_l == 3'd0) & mem_word[30];
            load_new[29:0]  = (mem_word[29:0] >> sh) & nmask;
            store_new[30]   = (fld_l == 3'd0) ? reg_word[30] : mem_word[30];
            store_new[29:0] = (mem_word[29:0] & ~fmask) | ((reg_word[29:0] & nmask) << sh);
        end

        out_valid_d = in_valid;
        load_out_d  = in_valid ? load_new  : load_out_q;
        store_out_d = in_valid ? store_new : store_out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            load_out_q  <= '0;
            store_out_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            load_out_q  <= load_out_d;
            store_out_q <= store_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign load_out  = load_out_q;
    assign store_out = store_out_q;

`ifdef MIX_FIELD_ERR_EN
    logic err_d, err_q;

    always_comb begin
        err_d = in_valid ? ~fld_ok : err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mix_field_unit.sv
// Purpose : self-checking bench for mix_field_unit (directed cases plus random captures).
// Latency : checks sampled 1 ns after the capturing rising edge.
// Backpressure: none; bench drives in_valid freely.
module tb_mix_field_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [5:0]  f;
    logic [30:0] mem_word;
    logic [30:0] reg_word;
    logic        out_valid;
    logic [30:0] load_out;
    logic [30:0] store_out;
`ifdef MIX_FIELD_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [30:0] exp_load;
    logic [30:0] exp_store;
    logic        exp_err;

    mix_field_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .f         (f),
        .mem_word  (mem_word),
        .reg_word  (reg_word),
        .out_valid (out_valid),
        .load_out  (load_out),
        .store_out (store_out)
`ifdef MIX_FIELD_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [30:0] mk(input logic s, input logic [5:0] b1, input logic [5:0] b2,
                                       input logic [5:0] b3, input logic [5:0] b4, input logic [5:0] b5);
        return {s, b1, b2, b3, b4, b5};
    endfunction

    task automatic check(input string tag, input logic [30:0] obs, input logic [30:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: move whole bytes by position. Byte i (1..5) lives at bits (5-i)*6 +: 6.
    task automatic model(input logic [5:0] ff, input logic [30:0] m, input logic [30:0] r,
                         output logic [30:0] ld, output logic [30:0] st, output logic e);
        int l, rr, lo, n;
        l  = int'(ff[5:3]);
        rr = int'(ff[2:0]);
        ld = '0;
        st = m;
        e  = 1'b0;
        if (l > rr || rr > 5) begin
            e = 1'b1;
        end else begin
            lo = (l == 0) ? 1 : l;
            n  = rr - lo + 1;
            if (l == 0) begin
                ld[30] = m[30];
                st[30] = r[30];
            end
            for (int k = 0; k < n; k++) begin
                // source byte lo+k lands at load byte 6-n+k; reg byte 6-n+k lands at byte lo+k
                ld[(n - 1 - k) * 6 +: 6]  = m[(5 - lo - k) * 6 +: 6];
                st[(5 - lo - k) * 6 +: 6] = r[(n - 1 - k) * 6 +: 6];
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic ov);
        check({tag, "_valid"}, {30'b0, out_valid}, {30'b0, ov});
        check({tag, "_load"},  load_out,  exp_load);
        check({tag, "_store"}, store_out, exp_store);
`ifdef MIX_FIELD_ERR_EN
        check({tag, "_err"},   {30'b0, err}, {30'b0, exp_err});
`endif
    endtask

    // Capture one operand set; in_valid stays high so consecutive calls are back-to-back.
    task automatic step(input logic [5:0] ff, input logic [30:0] m, input logic [30:0] r);
        @(negedge clk);
        in_valid = 1'b1;
        f        = ff;
        mem_word = m;
        reg_word = r;
        model(ff, m, r, exp_load, exp_store, exp_err);
        @(posedge clk);
        #1;
        check_outputs("step", 1'b1);
    endtask

    // One idle cycle with scrambled operands: results must hold.
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        f        = 6'($urandom);
        mem_word = 31'($urandom);
        reg_word = 31'($urandom);
        @(posedge clk);
        #1;
        check_outputs("idle", 1'b0);
    endtask

    logic [30:0] m0, r0;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        f         = '0;
        mem_word  = '0;
        reg_word  = '0;
        exp_load  = '0;
        exp_store = '0;
        exp_err   = 1'b0;
        m0 = mk(1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        r0 = mk(1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10);

        #1;
        check_outputs("reset", 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Loads
        step(6'd11, m0, r0);
        check("ld_1_3", load_out, mk(1'b0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3));
        idle();
        step(6'd0, m0, r0);
        check("ld_0_0", load_out, mk(1'b1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0));
        check("st_0_0", store_out, mk(1'b0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5));
        step(6'd5, m0, r0);
        check("ld_0_5", load_out, m0);

        // Stores
        step(6'd13, m0, r0);
        check("st_1_5", store_out, mk(1'b1, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10));
        step(6'd45, m0, r0);
        check("st_5_5", store_out, mk(1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10));
        step(6'd18, m0, r0);
        check("st_2_2", store_out, mk(1'b1, 6'd1, 6'd10, 6'd3, 6'd4, 6'd5));
        step(6'd1, m0, r0);
        check("st_0_1", store_out, mk(1'b0, 6'd10, 6'd2, 6'd3, 6'd4, 6'd5));

        // Invalid fields
        step(6'd26, m0, r0);
        check("inv_3_2_load",  load_out,  31'd0);
        check("inv_3_2_store", store_out, m0);
        step(6'd7, m0, r0);
        check("inv_0_7_load",  load_out,  31'd0);
        check("inv_0_7_store", store_out, m0);
        step(6'd5, m0, r0);
        idle();

        // Back-to-back
        step(6'd36, m0, r0);
        check("b2b_4_4", load_out, mk(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4));
        step(6'd37, m0, r0);
        check("b2b_4_5", load_out, mk(1'b0, 6'd0, 6'd0, 6'd0, 6'd4, 6'd5));

        // Asynchronous reset with a capture pending
        @(negedge clk);
        in_valid = 1'b1;
        f        = 6'd5;
        mem_word = m0;
        reg_word = r0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_load  = '0;
        exp_store = '0;
        exp_err   = 1'b0;
        check_outputs("async_rst", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 1'b0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        repeat (3) idle();

        // Random captures interleaved with idle cycles
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3) == 0) begin
                idle();
            end else begin
                step(6'($urandom), 31'($urandom), 31'($urandom));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_field_unit.md
Name: mix_field_unit

Overview:
- Registered MIX partial-field unit for the MIX CPU datapath.
- Extracts field (L:R) of a memory word for LDx/LDxN.
- Merges a register value into field (L:R) of a memory word for STx.
- Sits between the memory data register and the register file / memory write port.

Parameters:
- none; word format is fixed at 31 bits.
- Word format: bit 30 is the sign (1 = negative, 0 = positive).
- Bytes 1..5 are 6 bits each, at bits 29:24, 23:18, 17:12, 11:6 and 5:0.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  capture request for the current operands
- f  input  6  field spec F = 8L+R; L = f[5:3], R = f[2:0]
- mem_word  input  31  memory word: load source and store merge target
- reg_word  input  31  register value to be stored
- out_valid  output  1  one-cycle pulse, result registers updated
- load_out  output  31  extracted field, right-justified
- store_out  output  31  merged word to write back to memory
- err  output  1  invalid field flag; present only with MIX_FIELD_ERR_EN

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid, load_out, store_out and err are 0.
  - Reset is honoured immediately, including mid-operation.
  - A capture pending at reset assertion is discarded.
- Latency:
  - in_valid high at edge k → results registered at edge k.
  - out_valid is high for the cycle following edge k.
  - Back-to-back in_valid gives one result per cycle.
  - When in_valid is low, out_valid = 0 and load_out/store_out hold their last values.
- Valid field: L ≤ R ≤ 5.
- Load extraction, n = R − max(L,1) + 1 bytes:
  - If L = 0, sign = mem_word[30]; otherwise sign = 0 (positive).
  - Bytes max(L,1)..R of mem_word go to the low n byte positions of load_out, order preserved.
  - All higher bytes are zero.
  - (0:0) gives sign only, magnitude 0.
  - (0:5) gives mem_word unchanged.
- Store merge:
  - store_out starts as mem_word.
  - The low n bytes of reg_word replace bytes max(L,1)..R, order preserved.
  - If L = 0, sign = reg_word[30]; otherwise the mem_word sign is kept.
  - (0:0) replaces the sign only.
  - Bytes outside the field are untouched.
- Invalid field (L > R or R > 5):
  - load_out = +0 (all zero).
  - store_out = mem_word unchanged.
  - out_valid still pulses.
- Load and store results are both computed on every capture; the consumer picks one.
- Purely byte-lane selection; no arithmetic and no carries.

Optional Feature:
- Macro: MIX_FIELD_ERR_EN.
- Defined:
  - Adds the err output.
  - err is registered with the results: 1 for an invalid field, else 0.
  - err holds its value when in_valid is low; reset value 0.
- Undefined:
  - No err port.
  - Invalid-field data behaviour is identical.

Test Plan:
- Operands for the first four cases: mem_word = (−,1,2,3,4,5), reg_word = (+,6,7,8,9,10).
- Load, f=11 (1:3) → load_out = (+,0,0,1,2,3); f=0 (0:0) → (−,0,0,0,0,0); f=5 (0:5) → (−,1,2,3,4,5); out_valid pulses one cycle after the capture edge.
- Store, f=13 (1:5) → store_out = (−,6,7,8,9,10); f=45 (5:5) → (−,1,2,3,4,10); f=18 (2:2) → (−,1,10,3,4,5).
- Store with sign, f=1 (0:1) → store_out = (+,10,2,3,4,5); f=0 (0:0) → (+,1,2,3,4,5).
- Invalid field, f=26 (3:2) and f=7 (0:7) → load_out = 0, store_out = mem_word, err = 1 (with MIX_FIELD_ERR_EN); a following valid f=5 clears err.
- Reset and hold:
  - Assert reset_n low asynchronously mid-stream → all outputs 0 without waiting for a clock edge.
  - After release, idle cycles with in_valid = 0 → outputs stay 0.
  - Back-to-back captures f=36 then f=37 on mem_word (−,1,2,3,4,5) → load_out = (+,0,0,0,0,4) then (+,0,0,0,4,5) on consecutive cycles.
